// File: rtl/line_pkg.sv
// line_pkg: shared state, edge and direction types for line_sweeper.
// Build option: LINE_SWEEP_DWELL_EN adds the S_HOLD dwell state.
package line_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAW,
      S_DRAW_WAIT,
`ifdef LINE_SWEEP_DWELL_EN
      S_HOLD,
`endif
      S_ERASE,
      S_ERASE_WAIT,
      S_STEP
   } sweep_state_t;

   // TOP: endpoint A lies on y=0. RIGHT: endpoint A lies on x=SCREEN_W-1.
   typedef enum logic {
      EDGE_TOP   = 1'b0,
      EDGE_RIGHT = 1'b1
   } edge_t;

   typedef logic sweep_dir_t;
   localparam sweep_dir_t CW  = 1'b0;
   localparam sweep_dir_t CCW = 1'b1;

endpackage

// File: rtl/sweep_stepper.sv
// sweep_stepper: combinational next position of endpoint A along the
// top/right half-perimeter, with edge tracking and wrap detection.
// Sums and differences are formed one bit wider than the coordinates so
// clamping never sees an overflowed or underflowed value.
module sweep_stepper
   import line_pkg::*;
#(
   parameter int COORD_W  = 11,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int STEP     = 1
) (
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  edge_t              cur_edge,
   input  sweep_dir_t         dir,
   output logic [COORD_W-1:0] nx0,
   output logic [COORD_W-1:0] ny0,
   output edge_t              next_edge,
   output logic               wrap
);

   localparam logic [COORD_W:0] STEP_E = (COORD_W+1)'(STEP);
   localparam logic [COORD_W:0] MAX_X  = (COORD_W+1)'(SCREEN_W - 1);
   localparam logic [COORD_W:0] MAX_Y  = (COORD_W+1)'(SCREEN_H - 1);

   logic [COORD_W:0] x_ext, y_ext;
   logic [COORD_W:0] x_inc, y_inc, x_dec, y_dec;

   assign x_ext = {1'b0, x0};
   assign y_ext = {1'b0, y0};
   assign x_inc = x_ext + STEP_E;
   assign y_inc = y_ext + STEP_E;
   assign x_dec = x_ext - STEP_E;
   assign y_dec = y_ext - STEP_E;

   // Advance one step in the requested direction, clamping at corners.
   always_comb begin
      nx0       = x0;
      ny0       = y0;
      next_edge = cur_edge;
      wrap      = 1'b0;
      if (dir == CW) begin
         if (cur_edge == EDGE_TOP) begin
            if (x_inc >= MAX_X) begin
               nx0       = MAX_X[COORD_W-1:0];
               next_edge = EDGE_RIGHT;
            end else begin
               nx0 = x_inc[COORD_W-1:0];
            end
         end else if (y_ext == MAX_Y) begin
            nx0       = '0;
            ny0       = '0;
            next_edge = EDGE_TOP;
            wrap      = 1'b1;
         end else if (y_inc >= MAX_Y) begin
            ny0 = MAX_Y[COORD_W-1:0];
         end else begin
            ny0 = y_inc[COORD_W-1:0];
         end
      end else begin
         if (cur_edge == EDGE_RIGHT) begin
            // Sign bit set means the subtraction went below zero.
            if (y_dec[COORD_W] || (y_dec == '0)) begin
               ny0       = '0;
               next_edge = EDGE_TOP;
            end else begin
               ny0 = y_dec[COORD_W-1:0];
            end
         end else if (x_ext == '0) begin
            nx0       = MAX_X[COORD_W-1:0];
            ny0       = MAX_Y[COORD_W-1:0];
            next_edge = EDGE_RIGHT;
            wrap      = 1'b1;
         end else if (x_dec[COORD_W]) begin
            nx0 = '0;
         end else begin
            nx0 = x_dec[COORD_W-1:0];
         end
      end
   end

endmodule

// File: rtl/line_sweeper.sv
// line_sweeper: draw / erase / advance sequencer for a line through the
// screen centre, handshaking with line_drawer via start/done.
// Build option: LINE_SWEEP_DWELL_EN inserts S_HOLD (HOLD_CYCLES dwell)
// between draw completion and erase start.
module line_sweeper
   import line_pkg::*;
#(
   parameter int COORD_W     = 11,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int STEP        = 1,
   parameter int HOLD_CYCLES = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               dir,
   input  logic               done,
   output logic               start,
   output logic [COORD_W-1:0] x0,
   output logic [COORD_W-1:0] y0,
   output logic [COORD_W-1:0] x1,
   output logic [COORD_W-1:0] y1,
   output logic               pixel_color,
   output logic               sweep_wrap
);

   localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - 1);

   // Reject parameter sets the stepper cannot honour.
   if (STEP < 1 || STEP >= SCREEN_W || STEP >= SCREEN_H || HOLD_CYCLES < 0) begin : g_bad_params
      $error("line_sweeper: invalid STEP or HOLD_CYCLES");
   end

   sweep_state_t       state, next_state;
   edge_t              cur_edge, step_edge;
   logic [COORD_W-1:0] step_x0, step_y0;
   logic               step_wrap;

   sweep_stepper #(
      .COORD_W  (COORD_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .STEP     (STEP)
   ) u_stepper (
      .x0        (x0),
      .y0        (y0),
      .cur_edge  (cur_edge),
      .dir       (dir),
      .nx0       (step_x0),
      .ny0       (step_y0),
      .next_edge (step_edge),
      .wrap      (step_wrap)
   );

`ifdef LINE_SWEEP_DWELL_EN
   localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

   logic [HOLD_W-1:0] hold_cnt;

   // Dwell counter: runs 0..HOLD_CYCLES while in S_HOLD, else parked at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
      end else if (state == S_HOLD && hold_cnt != HOLD_LAST) begin
         hold_cnt <= hold_cnt + 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; done only matters in the two WAIT states.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:       if (enable) next_state = S_DRAW;
         S_DRAW:       next_state = S_DRAW_WAIT;
`ifdef LINE_SWEEP_DWELL_EN
         S_DRAW_WAIT:  if (done) next_state = S_HOLD;
         S_HOLD:       if (hold_cnt == HOLD_LAST) next_state = S_ERASE;
`else
         S_DRAW_WAIT:  if (done) next_state = S_ERASE;
`endif
         S_ERASE:      next_state = S_ERASE_WAIT;
         S_ERASE_WAIT: if (done) next_state = S_STEP;
         S_STEP:       next_state = enable ? S_DRAW : S_IDLE;
         default:      next_state = S_IDLE;
      endcase
   end

   // start/pixel_color are registered from next_state so they line up with
   // the S_DRAW / S_ERASE cycle; colour then holds until the next request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start       <= 1'b0;
         pixel_color <= 1'b0;
      end else begin
         start <= (next_state == S_DRAW) || (next_state == S_ERASE);
         if (next_state == S_DRAW) begin
            pixel_color <= 1'b1;
         end else if (next_state == S_ERASE) begin
            pixel_color <= 1'b0;
         end
      end
   end

   // Position registers: A, its mirror B and the edge update only in S_STEP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x0         <= '0;
         y0         <= '0;
         x1         <= MAX_X;
         y1         <= MAX_Y;
         cur_edge   <= EDGE_TOP;
         sweep_wrap <= 1'b0;
      end else begin
         sweep_wrap <= 1'b0;
         if (state == S_STEP) begin
            x0         <= step_x0;
            y0         <= step_y0;
            x1         <= MAX_X - step_x0;
            y1         <= MAX_Y - step_y0;
            cur_edge   <= step_edge;
            sweep_wrap <= step_wrap;
         end
      end
   end

endmodule
